// File: rtl/operand_fwd_if.sv
// Decode-to-forwarding-unit bus for operand_fwd_unit.
// The master drives the issue/operand inputs; the slave returns operands, the hazard flag and store data.
interface operand_fwd_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
);
    logic            hold_i;
    logic            issue_valid_i;
    logic [REGW-1:0] rs1_addr_i;
    logic [REGW-1:0] rs2_addr_i;
    logic [REGW-1:0] rd_addr_i;
    logic            rd_we_i;
    logic            rd_is_load_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [XLEN-1:0] alu_res_i;
    logic [XLEN-1:0] ld_data_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] imm_i;
    logic            a_pc_sel_i;
    logic            b_imm_sel_i;
    logic            br_un_i;
    logic [XLEN-1:0] op_a_o;
    logic [XLEN-1:0] op_b_o;
    logic            br_eq_o;
    logic            br_lt_o;
    logic            stall_o;
    logic [XLEN-1:0] st_data_o;
    logic            st_valid_o;

    modport master (
        output hold_i, issue_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rd_we_i,
               rd_is_load_i, rs1_data_i, rs2_data_i, alu_res_i, ld_data_i, pc_i, imm_i,
               a_pc_sel_i, b_imm_sel_i, br_un_i,
        input  op_a_o, op_b_o, br_eq_o, br_lt_o, stall_o, st_data_o, st_valid_o
    );

    modport slave (
        input  hold_i, issue_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rd_we_i,
               rd_is_load_i, rs1_data_i, rs2_data_i, alu_res_i, ld_data_i, pc_i, imm_i,
               a_pc_sel_i, b_imm_sel_i, br_un_i,
        output op_a_o, op_b_o, br_eq_o, br_lt_o, stall_o, st_data_o, st_valid_o
    );
endinterface

// File: rtl/operand_fwd_unit.sv
// Operand forwarding / load-use hazard unit tracking DEPTH in-flight destinations.
// Define OPERAND_FWD_STATS_EN to add saturating forward/stall event counters.
module operand_fwd_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REGW  = 5,
    parameter int unsigned DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    operand_fwd_if.slave bus
`ifdef OPERAND_FWD_STATS_EN
    ,
    output logic [31:0] fwd_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);
    // hist[0] is in EX (result still on alu_res_i), so data is only stored from hist[1] on
    logic            hist_v    [DEPTH];
    logic [REGW-1:0] hist_rd   [DEPTH];
    logic            hist_ld   [2];
    logic [XLEN-1:0] hist_data [1:DEPTH-1];

    logic [REGW-1:0] rs_addr  [2];
    logic [XLEN-1:0] rs_rf    [2];
    logic [XLEN-1:0] hist_val [2];
    logic [XLEN-1:0] fwd      [2];
    logic            hit      [2];
    logic            ex_load  [2];
    logic            stall;
    logic            issue_fire;

    assign rs_addr[0] = bus.rs1_addr_i;
    assign rs_addr[1] = bus.rs2_addr_i;
    assign rs_rf[0]   = bus.rs1_data_i;
    assign rs_rf[1]   = bus.rs2_data_i;

    // Scan oldest to youngest so the youngest matching entry overrides older ones
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            hit[s]      = 1'b0;
            ex_load[s]  = 1'b0;
            hist_val[s] = '0;
            for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
                if (hist_v[k] && hist_rd[k] == rs_addr[s]) begin
                    hit[s]      = 1'b1;
                    hist_val[s] = (k == 1 && hist_ld[1]) ? bus.ld_data_i : hist_data[k];
                end
            end
            if (hist_v[0] && hist_rd[0] == rs_addr[s]) begin
                hit[s]      = 1'b1;
                ex_load[s]  = hist_ld[0];
                hist_val[s] = bus.alu_res_i;
            end
            fwd[s] = (rs_addr[s] == '0) ? '0 : (hit[s] ? hist_val[s] : rs_rf[s]);
        end
    end

    assign stall      = bus.issue_valid_i & (ex_load[0] | ex_load[1]);
    assign issue_fire = bus.issue_valid_i & ~stall;

    assign bus.stall_o = stall;
    assign bus.op_a_o  = bus.a_pc_sel_i  ? bus.pc_i  : fwd[0];
    assign bus.op_b_o  = bus.b_imm_sel_i ? bus.imm_i : fwd[1];
    assign bus.br_eq_o = (fwd[0] == fwd[1]);
    assign bus.br_lt_o = bus.br_un_i ? (fwd[0] < fwd[1])
                                     : ($signed(fwd[0]) < $signed(fwd[1]));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                hist_v[k]  <= 1'b0;
                hist_rd[k] <= '0;
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                hist_data[k] <= '0;
            end
            hist_ld[0]     <= 1'b0;
            hist_ld[1]     <= 1'b0;
            bus.st_data_o  <= '0;
            bus.st_valid_o <= 1'b0;
        end else if (!bus.hold_i) begin
            hist_v[0]  <= issue_fire & bus.rd_we_i & (bus.rd_addr_i != '0);
            hist_rd[0] <= bus.rd_addr_i;
            hist_ld[0] <= bus.rd_is_load_i;
            hist_ld[1] <= hist_ld[0];
            for (int unsigned k = 1; k < DEPTH; k++) begin
                hist_v[k]  <= hist_v[k-1];
                hist_rd[k] <= hist_rd[k-1];
            end
            hist_data[1] <= bus.alu_res_i;
            for (int unsigned k = 2; k < DEPTH; k++) begin
                hist_data[k] <= (k == 2 && hist_ld[1]) ? bus.ld_data_i : hist_data[k-1];
            end
            bus.st_data_o  <= fwd[1];
            bus.st_valid_o <= issue_fire;
        end
    end

`ifdef OPERAND_FWD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (!bus.hold_i && issue_fire && (hit[0] || hit[1]) && fwd_cnt_o != '1)
                fwd_cnt_o <= fwd_cnt_o + 32'd1;
            if (stall && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
